// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the LCD command sequencer.
// State encoding, Pmod register bit positions and the default watchdog length.
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ERROR     = 3'd4
  } seq_state_e;

  localparam int LCD_REQ_BIT  = 7;
  localparam int LCD_RS_BIT   = 6;
  localparam int LCD_BUSY_BIT = 7;

  localparam int DEFAULT_TIMEOUT_CYCLES = 2000000;

endpackage

// File: rtl/lcd_seq_fifo.sv
// Synchronous FIFO with occupancy count and a flush that empties it in one cycle.
// Flush takes priority over a concurrent write or read.
module lcd_seq_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_fire, rd_fire;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_fire = wr_en & ~full & ~flush;
  assign rd_fire = rd_en & ~empty & ~flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count and pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Queues LCD commands/characters and hands them one at a time to the Picoblaze
// through the lcd_cmd/lcd_data/lcd_status REQ/BUSY handshake, with a per-phase watchdog.
module lcd_cmd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic             enq_is_data,
  input  logic [7:0]       enq_byte,
  input  logic             flush,
  output logic [7:0]       lcd_cmd,
  output logic [7:0]       lcd_data,
  input  logic [7:0]       lcd_status,
  output logic             seq_busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  seq_state_e      state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      lcd_cmd_q, lcd_cmd_d;
  logic [7:0]      lcd_data_q, lcd_data_d;
  logic            timeout_err_q, timeout_err_d;

  logic       fifo_pop, fifo_full, fifo_empty;
  logic [8:0] fifo_head;
  logic       busy, wd_hit, status_unused;

  assign busy          = lcd_status[LCD_BUSY_BIT];
  assign status_unused = ^lcd_status[6:0];
  assign wd_hit        = (wd_q == WD_LAST);

  lcd_seq_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (enq_valid),
    .wr_data ({enq_is_data, enq_byte}),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    lcd_cmd_d     = lcd_cmd_q;
    lcd_data_d    = lcd_data_q;
    timeout_err_d = flush ? 1'b0 : timeout_err_q;
    fifo_pop      = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (!busy) begin
          state_d = ST_IDLE;
        end else if (wd_hit) begin
          state_d       = ST_ERROR;
          timeout_err_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_INIT;
        end else if (!fifo_empty) begin
          fifo_pop                = 1'b1;
          lcd_data_d              = fifo_head[7:0];
          lcd_cmd_d               = '0;
          lcd_cmd_d[LCD_REQ_BIT]  = 1'b1;
          lcd_cmd_d[LCD_RS_BIT]   = fifo_head[8];
          state_d                 = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // BUSY already high counts as the acknowledge (level, not edge).
        if (busy) begin
          lcd_cmd_d[LCD_REQ_BIT] = 1'b0;
          state_d                = ST_WAIT_DONE;
        end else if (wd_hit) begin
          lcd_cmd_d     = '0;
          timeout_err_d = 1'b1;
          state_d       = ST_ERROR;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy) begin
          state_d = ST_IDLE;
        end else if (wd_hit) begin
          lcd_cmd_d     = '0;
          timeout_err_d = 1'b1;
          state_d       = ST_ERROR;
        end
      end
      ST_ERROR: begin
        lcd_cmd_d = '0;
        if (flush) state_d = ST_INIT;
      end
      default: state_d = ST_INIT;
    endcase
    wd_d = (state_d != state_q || state_q == ST_IDLE || state_q == ST_ERROR)
           ? '0 : wd_q + WD_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INIT;
      wd_q          <= '0;
      lcd_cmd_q     <= '0;
      lcd_data_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      lcd_cmd_q     <= lcd_cmd_d;
      lcd_data_q    <= lcd_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign lcd_cmd     = lcd_cmd_q;
  assign lcd_data    = lcd_data_q;
  assign timeout_err = timeout_err_q;
  assign enq_ready   = ~fifo_full;
  assign seq_busy    = (state_q != ST_IDLE) | ~fifo_empty;

endmodule
